div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
// - Iterative 32-bit signed/unsigned divider for the EX stage (DIV/DIVU).
// - Requester side of the pipeline stall handshake: drives stallreq_for_ex into CTRL and obeys the stall/flush CTRL returns.
// - Holds the EX instruction while dividing; result goes to HI (remainder) / LO (quotient) via EX.
// PARAMETERS
// - WIDTH  32  operand/result width; the iteration count equals WIDTH.
// PORTS
// - clk             in   1      rising-edge clock
// - rst             in   1      reset, synchronous, active-high
// - flush           in   1      pipeline flush (exception/eret); aborts any division
// - stall_ex        in   1      CTRL stall bit for the EX stage (stall[3] of StallBus)
// - start           in   1      EX holds a DIV/DIVU; stays high while the instruction sits in EX
// - is_signed       in   1      1=DIV, 0=DIVU; sampled with start in IDLE
// - dividend        in   WIDTH  rs operand; sampled with start in IDLE
// - divisor         in   WIDTH  rt operand; sampled with start in IDLE
// - stallreq_for_ex out  1      stall request to CTRL
// - result_valid    out  1      quotient/remainder valid (DONE state)
// - quotient        out  WIDTH  LO value
// - remainder       out  WIDTH  HI value
// BEHAVIOUR
// - States: IDLE, BUSY, DONE. Reset: state=IDLE, cnt=0, quotient=0, remainder=0; all outputs 0.
// - IDLE, start=1, flush=0, divisor!=0: latch |dividend|, |divisor| (abs only if is_signed), sign flags; cnt=0 -> BUSY.
// - IDLE, start=1, divisor==0: quotient=32'hFFFF_FFFF, remainder=dividend (raw) -> DONE.
// - BUSY: one restoring step per cycle: {r,q}<<=1; if r>=d then r-=d, q[0]=1. cnt++.
// - On the step with cnt==WIDTH-1: apply signs (quotient negated if signs differ; remainder takes dividend's sign) -> DONE.
// - Stepping ignores stall_ex; the divider is the stall source.
// - DONE: result_valid=1, outputs held. Goes to IDLE in the first cycle with stall_ex=0. Stays in DONE while stall_ex=1.
// - The same instruction is never restarted: DONE returns to IDLE only when EX advances.
// - stallreq_for_ex (combinational) = !flush & ((state==IDLE & start) | state==BUSY).
// - stallreq_for_ex is 0 in DONE.
// - Latency: nonzero divisor -> stallreq high 33 cycles (1 IDLE + 32 BUSY); result_valid on cycle 34.
// - Divide by zero -> stallreq high 1 cycle; result_valid the next cycle.
// - flush has priority over everything: any state -> IDLE next cycle; stallreq forced 0 that cycle.
// - After a flush, quotient/remainder are don't-care until the next DONE.
// - rst while BUSY/DONE: IDLE next edge, outputs cleared.
// - Signed overflow 0x8000_0000 / -1: quotient=0x8000_0000, remainder=0 (natural wrap, no trap).
// - Width rules: r and d are WIDTH bits. The comparison uses a WIDTH+1-bit difference so the top bit of the shifted r is not lost.
// STRUCTURE
// - lib/defines.vh: StallBus width, stall-bit index `STALL_EX, DIV state encodings, DIV_BY_ZERO_Q constant.
// - One sub-module: div_step. Combinational single restoring iteration: (r,q,d) -> (r',q').
// - div_unit keeps the FSM, counter, sign fix-up and handshake.
// TESTING
// - DIVU 100/7, stall_ex=0 -> stallreq high exactly 33 cycles; then q=14, r=2, result_valid 1 cycle, back to IDLE.
// - DIV -7/2 -> q=0xFFFF_FFFD (-3), r=0xFFFF_FFFF (-1). DIV 7/-2 -> q=-3, r=1.
// - DIV 0x8000_0000 / 0xFFFF_FFFF -> q=0x8000_0000, r=0. DIVU 0xFFFF_FFFF/1 -> q=0xFFFF_FFFF, r=0.
// - Divisor 0, dividend 0x1234 -> stallreq 1 cycle; q=0xFFFF_FFFF, r=0x1234.
// - Hold stall_ex=1 for 5 cycles after DONE -> result_valid and values held 5 cycles; IDLE after release; no second division.
// - flush at BUSY cycle 10 -> stallreq 0 that cycle, IDLE next cycle. A new start then runs a full 33-cycle division correctly.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative EX-stage divider.
package div_unit_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int STALL_W   = 6;
  localparam int STALL_EX  = 3;
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Magnitude of a two's-complement operand; 0x8000_0000 stays as-is and reads as 2^31 unsigned.
  function automatic logic [DIV_WIDTH-1:0] abs_if(input logic [DIV_WIDTH-1:0] v, input logic en);
    return (en && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction
endpackage

// File: rtl/div_unit_if.sv
// EX/CTRL <-> divider bundle: operands, pipeline control and results.
interface div_unit_if;
  import div_unit_pkg::*;
  logic                 flush;
  logic                 stall_ex;
  logic                 start;
  logic                 is_signed;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 stallreq_for_ex;
  logic                 result_valid;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;

  modport master (
    output flush, stall_ex, start, is_signed, dividend, divisor,
    input  stallreq_for_ex, result_valid, quotient, remainder
  );
  modport slave (
    input  flush, stall_ex, start, is_signed, dividend, divisor,
    output stallreq_for_ex, result_valid, quotient, remainder
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring division iteration, purely combinational.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] diff;
  logic           ge;

  // Shifted remainder carries one extra bit so it never overflows before the compare.
  assign r_shift = {r_i, q_i[WIDTH-1]};
  assign diff    = r_shift - {1'b0, d_i};
  assign ge      = (r_shift >= {1'b0, d_i});
  assign r_o     = ge ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
  assign q_o     = {q_i[WIDTH-2:0], ge};
endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU: FSM, iteration counter, sign fix-up and stall handshake.
module div_unit
  import div_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  div_unit_if.slave bus
);
  localparam int WIDTH = DIV_WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH-1:0] step_r, step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i(r_q), .q_i(q_q), .d_i(d_q), .r_o(step_r), .q_o(step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            quo_d   = DIV_BY_ZERO_Q;
            rem_d   = bus.dividend;
            state_d = ST_DONE;
          end else begin
            r_d     = '0;
            q_d     = abs_if(bus.dividend, bus.is_signed);
            d_d     = abs_if(bus.divisor, bus.is_signed);
            neg_q_d = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_r_d = bus.is_signed & bus.dividend[WIDTH-1];
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quo_d   = neg_q_q ? (~step_q + 1'b1) : step_q;
          rem_d   = neg_r_q ? (~step_r + 1'b1) : step_r;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Leave only when EX advances so the same instruction is never re-divided.
        if (!bus.stall_ex) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.stallreq_for_ex = !bus.flush &
                               (((state_q == ST_IDLE) & bus.start) | (state_q == ST_BUSY));
  assign bus.result_valid    = (state_q == ST_DONE);
  assign bus.quotient        = quo_q;
  assign bus.remainder       = rem_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed vector bench for div_unit: latency, results, stall hold, flush and reset.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  div_unit_if bus ();
  div_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one instruction from IDLE through DONE and back, checking latency and results.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input int ecyc);
    int n;
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    #1;
    n = 0;
    while (bus.stallreq_for_ex && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, " stall_cycles"}, 32'(n), 32'(ecyc));
    check({name, " valid"}, 32'(bus.result_valid), 32'd1);
    check({name, " quotient"}, bus.quotient, eq);
    check({name, " remainder"}, bus.remainder, er);
    bus.start = 1'b0;
    @(negedge clk);
    check({name, " back_idle"}, 32'({bus.result_valid, bus.stallreq_for_ex}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
    vecs[5] = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1};
    vecs[6] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
    vecs[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
    vecs[8] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1};
    vecs[9] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          33};

    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.stall_ex  = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    check("reset valid", 32'(bus.result_valid), 32'd0);
    check("reset stallreq", 32'(bus.stallreq_for_ex), 32'd0);
    check("reset quotient", bus.quotient, 32'd0);
    check("reset remainder", bus.remainder, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
              vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_cyc);

    // Hold DONE with stall_ex for 5 cycles, then let EX advance.
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd6;
    for (int n = 0; n < 40 && (n == 0 || bus.stallreq_for_ex); n++) @(negedge clk);
    bus.stall_ex = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold%0d valid", i), 32'(bus.result_valid), 32'd1);
      check($sformatf("hold%0d stallreq", i), 32'(bus.stallreq_for_ex), 32'd0);
      check($sformatf("hold%0d q", i), bus.quotient, 32'd8);
      check($sformatf("hold%0d r", i), bus.remainder, 32'd2);
      @(negedge clk);
    end
    bus.stall_ex = 1'b0;
    bus.start    = 1'b0;
    @(negedge clk);
    check("release idle", 32'({bus.result_valid, bus.stallreq_for_ex}), 32'd0);
    @(negedge clk);
    check("no restart", 32'({bus.result_valid, bus.stallreq_for_ex}), 32'd0);

    // Flush partway through BUSY.
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    repeat (11) @(negedge clk);
    #1;
    check("pre-flush stallreq", 32'(bus.stallreq_for_ex), 32'd1);
    bus.flush = 1'b1;
    #1;
    check("flush stallreq", 32'(bus.stallreq_for_ex), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    check("post-flush idle", 32'({bus.result_valid, bus.stallreq_for_ex}), 32'd0);
    repeat (30) @(negedge clk);
    check("post-flush no done", 32'(bus.result_valid), 32'd0);
    run_div("after_flush", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 33);

    // Synchronous reset mid-division clears everything.
    bus.start = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd5;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst busy stallreq", 32'(bus.stallreq_for_ex), 32'd0);
    check("rst busy valid", 32'(bus.result_valid), 32'd0);
    check("rst busy quotient", bus.quotient, 32'd0);
    check("rst busy remainder", bus.remainder, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
